// File: rtl/sequenciador_gray.sv
// Sweep controller: walks a binary index from first to last (up or down, optional loop)
// and presents each binary/Gray pair over a valid/ready handshake.

module conversor_binario_grey #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] binario,
  output logic [WIDTH-1:0] gray
);

  assign gray = binario ^ (binario >> 1);

endmodule

module sequenciador_gray #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] first,
  input  logic [WIDTH-1:0] last,
  input  logic             loop,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] binario,
  output logic [WIDTH-1:0] gray,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_binario;
  logic [WIDTH-1:0] r_first;
  logic [WIDTH-1:0] r_last;
  logic             r_loop;
  logic             r_dir_down;
  logic             w_xfer;
  logic             w_at_last;
  logic [WIDTH-1:0] w_step;

  assign w_xfer    = (r_state == RUN) && out_ready;
  assign w_at_last = (r_binario == r_last);
  assign w_step    = r_dir_down ? (r_binario - WIDTH'(1)) : (r_binario + WIDTH'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (start) w_next_state = RUN;
      RUN: begin
        if (abort) begin
          w_next_state = IDLE;
        end else if (w_xfer && w_at_last && !r_loop) begin
          w_next_state = DONE;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (r_state)
      RUN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Index and sweep parameters; abort freezes the index even when a transfer coincides.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_binario  <= '0;
      r_first    <= '0;
      r_last     <= '0;
      r_loop     <= 1'b0;
      r_dir_down <= 1'b0;
    end else if (r_state == IDLE) begin
      if (start) begin
        r_binario  <= first;
        r_first    <= first;
        r_last     <= last;
        r_loop     <= loop;
        r_dir_down <= (first > last);
      end
    end else if (w_xfer && !abort) begin
      if (!w_at_last) begin
        r_binario <= w_step;
      end else if (r_loop) begin
        r_binario <= r_first;
      end
    end
  end

  assign binario = r_binario;

  conversor_binario_grey #(
    .WIDTH(WIDTH)
  ) u_conv (
    .binario(r_binario),
    .gray   (gray)
  );

endmodule

// File: tb/tb_sequenciador_gray.sv
// Scoreboard bench for sequenciador_gray: stimulus pushes expected words, a negedge
// monitor pops and compares on every transfer.

module tb_sequenciador_gray;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [3:0] first;
  logic [3:0] last;
  logic       loop;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] binario;
  logic [3:0] gray;
  logic       busy;
  logic       done;

  int checks = 0;
  int failures = 0;
  int done_seen = 0;
  logic [7:0] sb[$];
  logic       stall_prev = 1'b0;
  logic [3:0] bin_prev = '0;

  always #5 clk = ~clk;

  sequenciador_gray #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .first    (first),
    .last     (last),
    .loop     (loop),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .binario  (binario),
    .gray     (gray),
    .busy     (busy),
    .done     (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] b, input logic [3:0] g);
    sb.push_back({b, g});
  endtask

  always @(negedge clk) begin
    logic [7:0] e;
    if (rst_n === 1'b1) begin
      if (done) done_seen++;
      if (stall_prev && out_valid) chk("stall_hold", binario, bin_prev);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=%0d required=none t=%0t", binario, $time);
        end else begin
          e = sb.pop_front();
          chk("word_bin", binario, e[7:4]);
          chk("word_gray", gray, e[3:0]);
        end
      end
      stall_prev = out_valid && !out_ready;
      bin_prev   = binario;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Sweep parameters are scrambled right after start to show they are latched.
  task automatic launch(input logic [3:0] f, input logic [3:0] l, input logic lp);
    @(posedge clk); #1;
    first = f; last = l; loop = lp; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    first = 4'($urandom);
    last  = 4'($urandom);
    loop  = 1'($urandom);
  endtask

  task automatic wait_done(input int mode, input int exp_lat, input string name);
    bit seen = 1'b0;
    for (int cyc = 1; cyc <= 200 && !seen; cyc++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        chk({name, "_done_lat"}, cyc, exp_lat);
      end else begin
        @(posedge clk); #1;
        if (mode == 1) out_ready = (cyc % 3 == 0);
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_done_timeout actual=none required=done", name);
    end
    @(negedge clk);
    chk({name, "_busy_after"}, busy, 0);
    chk({name, "_done_once"}, done, 0);
    chk({name, "_valid_after"}, out_valid, 0);
    chk({name, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    logic [3:0] up_gray [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                                 4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                 4'b1010, 4'b1011, 4'b1001, 4'b1000};

    rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      start = 1'($urandom); abort = 1'($urandom); first = 4'($urandom);
      last = 4'($urandom); loop = 1'($urandom); out_ready = 1'($urandom);
    end
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bin", binario, 0);
    chk("rst_gray", gray, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b0; abort = 1'b0; loop = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("idle_valid", out_valid, 0);

    // Full up sweep 0..15
    for (int i = 0; i < 16; i++) push(4'(i), up_gray[i]);
    launch(4'd0, 4'd15, 1'b0);
    wait_done(0, 17, "up");

    // Down sweep 5..2 with backpressure
    push(4'd5, 4'b0111); push(4'd4, 4'b0110); push(4'd3, 4'b0010); push(4'd2, 4'b0011);
    out_ready = 1'b1;
    launch(4'd5, 4'd2, 1'b0);
    wait_done(1, 11, "down_bp");

    // Loop 14..15, abort coinciding with the 6th transfer
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(4'd14, 4'b1001); push(4'd15, 4'b1000);
    end
    d0 = done_seen;
    launch(4'd14, 4'd15, 1'b1);
    repeat (5) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_bin_hold", binario, 15);
    chk("abort_gray_hold", gray, 4'b1000);
    repeat (4) @(negedge clk);
    chk("abort_no_done", done_seen - d0, 0);
    chk("abort_sb_empty", sb.size(), 0);
    push(4'd3, 4'b0010);
    launch(4'd3, 4'd3, 1'b0);
    wait_done(0, 2, "after_abort");

    // Single word 9, start during DONE is ignored
    push(4'd9, 4'b1101);
    launch(4'd9, 4'd9, 1'b0);
    @(posedge clk); #1;
    first = 4'd1; last = 4'd2; loop = 1'b0; start = 1'b1;
    @(negedge clk);
    chk("single_done", done, 1);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("single_start_ign1", out_valid, 0);
    chk("single_busy", busy, 0);
    @(negedge clk);
    chk("single_start_ign2", out_valid, 0);
    chk("single_sb_empty", sb.size(), 0);

    // Reset while binario=7 during an up sweep
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) push(4'(i), up_gray[i]);
    launch(4'd0, 4'd15, 1'b0);
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_bin_before", binario, 7);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_bin", binario, 0);
    chk("midrst_gray", gray, 0);
    chk("midrst_sb_empty", sb.size(), 0);
    push(4'd12, 4'b1010); push(4'd11, 4'b1110); push(4'd10, 4'b1111);
    launch(4'd12, 4'd10, 1'b0);
    wait_done(0, 4, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sequenciador_gray.md
# sequenciador_gray

Sweep controller for the binary-to-Gray converter (`conversor_binario_grey`). On a start command it walks a binary index from a programmed first value to a programmed last value, inclusive, in either direction. It feeds each index through an internal converter instance and presents each binary/Gray pair to a downstream consumer over a valid/ready handshake. It is the sequencing front end for any Gray-coded stimulus or position stream in the design.

## Interface
- `WIDTH`, default 4, width of the index and the Gray code.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  launch a sweep; sampled only in IDLE.
- `abort`  in  1  terminate the sweep; sampled in RUN and DONE.
- `first`  in  WIDTH  first index; latched when `start` is accepted.
- `last`  in  WIDTH  last index, inclusive; latched when `start` is accepted.
- `loop`  in  1  restart from `first` after `last`; latched when `start` is accepted.
- `out_ready`  in  1  consumer accepts the current word.
- `out_valid`  out  1  `binario`/`gray` hold a valid word.
- `binario`  out  WIDTH  current binary index (registered).
- `gray`  out  WIDTH  Gray code of `binario`, from the internal `conversor_binario_grey` instance (combinational from the `binario` register).
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse at normal sweep completion.

## Operation
- **Reset** (`rst_n`=0 at an edge): state IDLE, `binario`=0, `gray`=0, `out_valid`=0, `busy`=0, `done`=0, latched `first`/`last`/`loop`/direction cleared to 0. Reset has priority over every other input, including mid-sweep.
- **Direction**: latched at start as up if `first` <= `last`, otherwise down. Unsigned compare.
- **Stepping**: up steps +1, down steps -1. The index never passes `last`, so no arithmetic wrap occurs. Counter width is exactly WIDTH.
- **Transfer**: a cycle with `out_valid`=1 and `out_ready`=1.
- **States**:
  - **IDLE**: `out_valid`=0, `busy`=0. If `start`=1: latch inputs, set `binario`<=`first`, go to RUN. `abort` is ignored here.
  - **RUN**: `out_valid`=1, `busy`=1. `binario` and `gray` stay stable until a transfer occurs. On a transfer:
    - If `binario`!=`last`: step the index.
    - Else if latched `loop`=1: `binario`<=latched `first`, stay in RUN.
    - Else: go to DONE.
    - No transfer: hold all outputs.
  - **DONE**: `out_valid`=0, `busy`=0, `done`=1 for exactly this cycle. Next state is IDLE unconditionally. `start` is ignored here.
- **abort**: in RUN or DONE, the next state is IDLE with `done`=0 and `binario` holding its value.
  - `abort` has priority over stepping.
  - A handshake coinciding with `abort` still counts as consumed by the downstream side, but no further words are produced.
- **first==last**: a single word per sweep. With `loop`=1, that same word repeats on every transfer.
- Changes to `first`, `last` or `loop` during RUN have no effect.

## Timing
- `start` sampled at edge N: `out_valid`=1 with `binario`=`first` from edge N (cycle N+1).
- Throughput is one word per cycle while `out_ready`=1. There are no bubbles, including across the `last`->`first` loop restart.
- A sweep of L = |`last`-`first`|+1 words with `out_ready` held high:
  - Final transfer occurs in cycle N+L.
  - `done`=1 in cycle N+L+1.
  - IDLE in cycle N+L+2, the earliest cycle in which a new `start` is accepted.
- `abort` at edge M: `out_valid`=0 and IDLE from cycle M+1.
- `gray` has zero latency relative to `binario`; both change only on clock edges.

## Test plan
- **Reset values**: hold `rst_n`=0 for 3 cycles with random inputs -> all outputs 0, state IDLE.
- **Full up sweep**: `first`=0, `last`=15, `out_ready`=1, `start` pulse -> 16 consecutive words with `gray` = 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000. Then a one-cycle `done`, and `busy` low after it.
- **Down sweep with backpressure**: `first`=5, `last`=2, `out_ready` toggling 1,0,0,1,... -> words are accepted in order `binario`=5,4,3,2 (`gray`=0111,0110,0010,0011). Outputs stay stable while `out_ready`=0, and `done` fires once after the 4th transfer.
- **Loop and abort**: `first`=14, `last`=15, `loop`=1, `out_ready`=1 -> `binario` sequence 14,15,14,15,... After asserting `abort`: `out_valid`=0 on the next cycle, `done` never pulses, and a new `start` in IDLE is accepted.
- **Single word**: `first`=`last`=9, `loop`=0 -> one word (`gray`=1101), then `done`. A `start` asserted during the DONE cycle is ignored.
- **Reset mid-run**: `rst_n`=0 for one edge during an up sweep at `binario`=7 -> all outputs 0 on the next cycle. A later `start` runs a fresh sweep from the new `first`.
